// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions used by the PTW request controller.
package rvh_l1d_pkg;

    localparam int unsigned PTW_ID_WIDTH = 1;
    localparam int unsigned PADDR_WIDTH  = 56;
    localparam int unsigned XLEN         = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT     = 3'd2,
        WAIT_RPL = 3'd3,
        RESP     = 3'd4,
        DRAIN    = 3'd5
    } ptw_req_ctrl_state_e;

endpackage

// File: rtl/rvh_l1d_ptw_req_ctrl.sv
// PTW front-end to the L1D load pipe: one walk in flight, replay parking, flush draining.
module rvh_l1d_ptw_req_ctrl
    import rvh_l1d_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ptw_walk_req_vld_i,
    output logic                    ptw_walk_req_rdy_o,
    input  logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i,
    input  logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i,

    output logic                    rb_walk_req_vld_o,
    output logic [PTW_ID_WIDTH-1:0] rb_walk_req_id_o,
    output logic [PADDR_WIDTH-1:0]  rb_walk_req_addr_o,

    input  logic                    ptw_walk_replay_req_vld_i,
    input  logic [PTW_ID_WIDTH-1:0] ptw_walk_replay_req_id_i,
    input  logic [PADDR_WIDTH-1:0]  ptw_walk_replay_req_paddr_i,
    output logic                    ptw_walk_replay_req_rdy_o,

    output logic                    l1d_ptw_req_vld_o,
    input  logic                    l1d_ptw_req_rdy_i,
    output logic [PTW_ID_WIDTH-1:0] l1d_ptw_req_id_o,
    output logic [PADDR_WIDTH-1:0]  l1d_ptw_req_paddr_o,
    output logic                    l1d_ptw_req_is_replay_o,

    input  logic                    l1d_ptw_resp_vld_i,
    input  logic [PTW_ID_WIDTH-1:0] l1d_ptw_resp_id_i,
    input  logic                    l1d_ptw_resp_replay_i,
    input  logic [XLEN-1:0]         l1d_ptw_resp_pte_i,

    output logic                    ptw_walk_resp_vld_o,
    input  logic                    ptw_walk_resp_rdy_i,
    output logic [PTW_ID_WIDTH-1:0] ptw_walk_resp_id_o,
    output logic [XLEN-1:0]         ptw_walk_resp_pte_o,

    input  logic                    ptw_flush_i,
    output logic                    ptw_id_err_o
);

    ptw_req_ctrl_state_e     state_q, state_d;
    logic [PTW_ID_WIDTH-1:0] id_q, id_d;
    logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic                    is_replay_q, is_replay_d;
    logic [XLEN-1:0]         pte_q, pte_d;
    logic                    id_err_q, id_err_d;

    logic fresh_acc;
    logic resp_match;

    // Handshake and output decode; walker accept is blocked during a flush.
    always_comb begin
        ptw_walk_req_rdy_o        = (state_q == IDLE) & ~ptw_flush_i;
        ptw_walk_replay_req_rdy_o = (state_q == WAIT_RPL);
        fresh_acc                 = ptw_walk_req_vld_i & ptw_walk_req_rdy_o;
        resp_match                = l1d_ptw_resp_vld_i & (l1d_ptw_resp_id_i == id_q);
        rb_walk_req_vld_o         = fresh_acc;
        rb_walk_req_id_o          = ptw_walk_req_id_i;
        rb_walk_req_addr_o        = ptw_walk_req_addr_i;
        l1d_ptw_req_vld_o         = (state_q == ISSUE);
        l1d_ptw_req_id_o          = id_q;
        l1d_ptw_req_paddr_o       = paddr_q;
        l1d_ptw_req_is_replay_o   = is_replay_q;
        ptw_walk_resp_vld_o       = (state_q == RESP);
        ptw_walk_resp_id_o        = id_q;
        ptw_walk_resp_pte_o       = pte_q;
        ptw_id_err_o              = id_err_q;
    end

    // Next-state and payload capture.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        paddr_d     = paddr_q;
        is_replay_d = is_replay_q;
        pte_d       = pte_q;
        id_err_d    = id_err_q;
        unique case (state_q)
            IDLE: begin
                if (fresh_acc) begin
                    id_d        = ptw_walk_req_id_i;
                    paddr_d     = ptw_walk_req_addr_i;
                    is_replay_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // An accept in the flush cycle is already owned by L1D, so drain it.
                if (l1d_ptw_req_rdy_i) begin
                    state_d = ptw_flush_i ? DRAIN : WAIT;
                end else if (ptw_flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (l1d_ptw_resp_vld_i && !resp_match) begin
                    id_err_d = 1'b1;
                end
                if (ptw_flush_i) begin
                    state_d = resp_match ? IDLE : DRAIN;
                end else if (resp_match) begin
                    if (l1d_ptw_resp_replay_i) begin
                        state_d = WAIT_RPL;
                    end else begin
                        pte_d   = l1d_ptw_resp_pte_i;
                        state_d = RESP;
                    end
                end
            end
            WAIT_RPL: begin
                if (ptw_flush_i) begin
                    state_d = IDLE;
                end else if (ptw_walk_replay_req_vld_i) begin
                    id_d        = ptw_walk_replay_req_id_i;
                    paddr_d     = ptw_walk_replay_req_paddr_i;
                    is_replay_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            RESP: begin
                if (ptw_flush_i || ptw_walk_resp_rdy_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (resp_match) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            paddr_q     <= '0;
            is_replay_q <= 1'b0;
            pte_q       <= '0;
            id_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            paddr_q     <= paddr_d;
            is_replay_q <= is_replay_d;
            pte_q       <= pte_d;
            id_err_q    <= id_err_d;
        end
    end

endmodule

// File: tb/tb_rvh_l1d_ptw_req_ctrl.sv
// Bench for the PTW request controller: directed walks plus randomized walk scenarios.
module tb_rvh_l1d_ptw_req_ctrl;
    import rvh_l1d_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_vld, req_rdy;
    logic [PTW_ID_WIDTH-1:0] req_id;
    logic [PADDR_WIDTH-1:0]  req_addr;
    logic                    rb_vld;
    logic [PTW_ID_WIDTH-1:0] rb_id;
    logic [PADDR_WIDTH-1:0]  rb_addr;
    logic                    rpl_vld, rpl_rdy;
    logic [PTW_ID_WIDTH-1:0] rpl_id;
    logic [PADDR_WIDTH-1:0]  rpl_paddr;
    logic                    l1d_vld, l1d_rdy, l1d_is_rpl;
    logic [PTW_ID_WIDTH-1:0] l1d_id;
    logic [PADDR_WIDTH-1:0]  l1d_paddr;
    logic                    rsp_vld, rsp_replay;
    logic [PTW_ID_WIDTH-1:0] rsp_id;
    logic [XLEN-1:0]         rsp_pte;
    logic                    wr_vld, wr_rdy;
    logic [PTW_ID_WIDTH-1:0] wr_id;
    logic [XLEN-1:0]         wr_pte;
    logic                    flush, id_err;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    rvh_l1d_ptw_req_ctrl dut (
        .clk(clk), .rst(rst),
        .ptw_walk_req_vld_i(req_vld), .ptw_walk_req_rdy_o(req_rdy),
        .ptw_walk_req_id_i(req_id), .ptw_walk_req_addr_i(req_addr),
        .rb_walk_req_vld_o(rb_vld), .rb_walk_req_id_o(rb_id), .rb_walk_req_addr_o(rb_addr),
        .ptw_walk_replay_req_vld_i(rpl_vld), .ptw_walk_replay_req_id_i(rpl_id),
        .ptw_walk_replay_req_paddr_i(rpl_paddr), .ptw_walk_replay_req_rdy_o(rpl_rdy),
        .l1d_ptw_req_vld_o(l1d_vld), .l1d_ptw_req_rdy_i(l1d_rdy),
        .l1d_ptw_req_id_o(l1d_id), .l1d_ptw_req_paddr_o(l1d_paddr),
        .l1d_ptw_req_is_replay_o(l1d_is_rpl),
        .l1d_ptw_resp_vld_i(rsp_vld), .l1d_ptw_resp_id_i(rsp_id),
        .l1d_ptw_resp_replay_i(rsp_replay), .l1d_ptw_resp_pte_i(rsp_pte),
        .ptw_walk_resp_vld_o(wr_vld), .ptw_walk_resp_rdy_i(wr_rdy),
        .ptw_walk_resp_id_o(wr_id), .ptw_walk_resp_pte_o(wr_pte),
        .ptw_flush_i(flush), .ptw_id_err_o(id_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic l1d_resp(input logic [PTW_ID_WIDTH-1:0] id, input bit replay, input logic [XLEN-1:0] pte);
        rsp_vld = 1'b1; rsp_id = id; rsp_replay = replay; rsp_pte = pte;
    endtask

    task automatic clr_resp();
        rsp_vld = 1'b0; rsp_replay = 1'b0;
    endtask

    // One walk as seen from outside. scen: 0 normal, 1 flush in ISSUE, 2 flush with L1D accept,
    // 3 flush in WAIT, 4 flush with response in WAIT, 5 flush while parked on replay, 6 flush in RESP.
    task automatic walk(input logic [PTW_ID_WIDTH-1:0] id, input logic [PADDR_WIDTH-1:0] addr,
                        input logic [XLEN-1:0] pte, input int bp_issue, input int nrep,
                        input int bp_resp, input int scen, input bit mism);
        logic [PADDR_WIDTH-1:0] cur;
        bit rpl;
        cur = addr;
        rpl = 1'b0;
        req_vld = 1'b1; req_id = id; req_addr = addr;
        #1;
        chk("req_rdy_idle", req_rdy, 1);
        chk("rb_vld", rb_vld, 1);
        chk("rb_id", rb_id, id);
        chk("rb_addr", rb_addr, addr);
        tick();
        req_vld = 1'b0;
        #1;
        for (int r = 0; r <= nrep; r++) begin
            for (int c = 0; c < bp_issue; c++) begin
                chk("l1d_vld_hold", l1d_vld, 1);
                chk("l1d_id_hold", l1d_id, id);
                chk("l1d_paddr_hold", l1d_paddr, cur);
                chk("l1d_is_rpl", l1d_is_rpl, rpl);
                chk("req_rdy_busy", req_rdy, 0);
                tick(); #1;
            end
            if (scen == 1 && r == nrep) begin
                flush = 1'b1; #1;
                chk("l1d_vld_flush", l1d_vld, 1);
                tick(); flush = 1'b0; #1;
                chk("l1d_vld_after_flush", l1d_vld, 0);
                chk("req_rdy_after_flush", req_rdy, 1);
                return;
            end
            l1d_rdy = 1'b1;
            if (scen == 2 && r == nrep) flush = 1'b1;
            #1;
            chk("l1d_vld_acc", l1d_vld, 1);
            chk("l1d_paddr_acc", l1d_paddr, cur);
            chk("l1d_is_rpl_acc", l1d_is_rpl, rpl);
            tick(); l1d_rdy = 1'b0; flush = 1'b0; #1;
            chk("l1d_vld_done", l1d_vld, 0);
            if (scen == 2 && r == nrep) begin
                chk("req_rdy_drain", req_rdy, 0);
                l1d_resp(id, 1'b0, pte); tick(); clr_resp(); #1;
                chk("wr_vld_drained", wr_vld, 0);
                chk("req_rdy_drain_done", req_rdy, 1);
                return;
            end
            if (mism && r == 0) begin
                l1d_resp(~id, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0); tick(); clr_resp(); #1;
                exp_err = 1'b1;
                chk("id_err_set", id_err, exp_err);
                chk("wr_vld_mism", wr_vld, 0);
            end
            chk("wr_vld_wait", wr_vld, 0);
            chk("req_rdy_wait", req_rdy, 0);
            chk("rpl_rdy_wait", rpl_rdy, 0);
            tick(); #1;
            if (scen == 3 && r == nrep) begin
                flush = 1'b1; tick(); flush = 1'b0; #1;
                chk("req_rdy_drain", req_rdy, 0);
                l1d_resp(id, 1'b0, pte); tick(); clr_resp(); #1;
                chk("wr_vld_drained", wr_vld, 0);
                chk("req_rdy_drain_done", req_rdy, 1);
                return;
            end
            if (scen == 4 && r == nrep) begin
                flush = 1'b1; l1d_resp(id, 1'b0, pte); tick(); flush = 1'b0; clr_resp(); #1;
                chk("wr_vld_flush_resp", wr_vld, 0);
                chk("req_rdy_flush_resp", req_rdy, 1);
                return;
            end
            if (r < nrep) begin
                l1d_resp(id, 1'b1, {$urandom(), $urandom()}); tick(); clr_resp(); #1;
                chk("wr_vld_replay", wr_vld, 0);
                chk("rpl_rdy", rpl_rdy, 1);
                chk("l1d_vld_parked", l1d_vld, 0);
                if (scen == 5 && r == nrep - 1) begin
                    flush = 1'b1; tick(); flush = 1'b0; #1;
                    chk("req_rdy_flush_rpl", req_rdy, 1);
                    chk("rpl_rdy_flush_rpl", rpl_rdy, 0);
                    chk("wr_vld_flush_rpl", wr_vld, 0);
                    return;
                end
                tick(); #1;
                cur = PADDR_WIDTH'({$urandom(), $urandom()});
                rpl_vld = 1'b1; rpl_id = id; rpl_paddr = cur;
                tick(); rpl_vld = 1'b0; #1;
                rpl = 1'b1;
            end else begin
                l1d_resp(id, 1'b0, pte); tick(); clr_resp(); #1;
            end
        end
        for (int c = 0; c < bp_resp; c++) begin
            chk("wr_vld_hold", wr_vld, 1);
            chk("wr_id_hold", wr_id, id);
            chk("wr_pte_hold", wr_pte, pte);
            chk("req_rdy_resp", req_rdy, 0);
            tick(); #1;
        end
        if (scen == 6) begin
            flush = 1'b1; #1;
            chk("wr_vld_flush", wr_vld, 1);
            tick(); flush = 1'b0; #1;
            chk("wr_vld_flushed", wr_vld, 0);
            chk("req_rdy_flushed", req_rdy, 1);
            return;
        end
        wr_rdy = 1'b1; #1;
        chk("wr_vld", wr_vld, 1);
        chk("wr_id", wr_id, id);
        chk("wr_pte", wr_pte, pte);
        tick(); wr_rdy = 1'b0; #1;
        chk("wr_vld_done", wr_vld, 0);
        chk("req_rdy_done", req_rdy, 1);
        chk("id_err_sticky", id_err, exp_err);
    endtask

    initial begin
        rst = 1'b0;
        req_vld = 1'b0; req_id = '0; req_addr = '0;
        rpl_vld = 1'b0; rpl_id = '0; rpl_paddr = '0;
        l1d_rdy = 1'b0; rsp_vld = 1'b0; rsp_id = '0; rsp_replay = 1'b0; rsp_pte = '0;
        wr_rdy = 1'b0; flush = 1'b0;
        #12;
        chk("rst_l1d_vld", l1d_vld, 0);
        chk("rst_wr_vld", wr_vld, 0);
        chk("rst_rb_vld", rb_vld, 0);
        chk("rst_id_err", id_err, 0);
        chk("rst_wr_pte", wr_pte, 0);
        chk("rst_l1d_paddr", l1d_paddr, 0);
        rst = 1'b1;
        tick(); #1;
        chk("rst_req_rdy", req_rdy, 1);

        // Directed walks.
        walk(1'b1, 56'h8000_1000, 64'hDEAD_0001, 0, 0, 0, 0, 1'b0);
        walk(1'b1, 56'h8000_1000, 64'hDEAD_0002, 0, 1, 0, 0, 1'b0);
        walk(1'b0, 56'h8000_2000, 64'hDEAD_0003, 5, 0, 3, 0, 1'b0);
        walk(1'b1, 56'h8000_3000, 64'hDEAD_0004, 0, 0, 0, 3, 1'b0);
        walk(1'b0, 56'h8000_4000, 64'hDEAD_0005, 0, 0, 0, 0, 1'b1);

        // Flush while idle blocks the walker.
        req_vld = 1'b1; req_id = 1'b1; req_addr = 56'h1234; flush = 1'b1; #1;
        chk("req_rdy_idle_flush", req_rdy, 0);
        chk("rb_vld_idle_flush", rb_vld, 0);
        tick(); req_vld = 1'b0; flush = 1'b0; #1;
        chk("l1d_vld_idle_flush", l1d_vld, 0);
        chk("req_rdy_idle_flush_after", req_rdy, 1);

        // Randomized walks.
        for (int i = 0; i < 60; i++) begin
            int scen;
            int nrep;
            scen = int'($urandom_range(0, 6));
            nrep = int'($urandom_range(0, 2));
            if (scen == 5 && nrep == 0) nrep = 1;
            walk(PTW_ID_WIDTH'($urandom()), PADDR_WIDTH'({$urandom(), $urandom()}),
                 {$urandom(), $urandom()}, int'($urandom_range(0, 3)), nrep,
                 int'($urandom_range(0, 3)), scen, ($urandom_range(0, 3) == 0));
            repeat (int'($urandom_range(0, 2))) tick();
        end

        // Asynchronous reset while waiting on L1D.
        req_vld = 1'b1; req_id = 1'b0; req_addr = 56'hABC000;
        tick(); req_vld = 1'b0; l1d_rdy = 1'b1;
        tick(); l1d_rdy = 1'b0; #1;
        chk("req_rdy_pre_rst", req_rdy, 0);
        #1;
        rst = 1'b0; exp_err = 1'b0; #1;
        chk("arst_l1d_vld", l1d_vld, 0);
        chk("arst_wr_vld", wr_vld, 0);
        chk("arst_rb_vld", rb_vld, 0);
        chk("arst_id_err", id_err, exp_err);
        tick(); rst = 1'b1; tick(); #1;
        chk("arst_req_rdy", req_rdy, 1);
        walk(1'b1, 56'h8000_5000, 64'hDEAD_0006, 1, 0, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
